// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column per dwell, debounces a
// single-row hit on the frozen column, and reports one key code per press.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       sys_rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t           state_reg, state_next;
    logic [3:0]       row_meta_reg, row_sync_reg;
    logic [DIV_W-1:0] div_reg, div_next;
    logic [1:0]       col_idx_reg, col_idx_next;
    logic [3:0]       col_out_reg, col_out_next;
    logic [3:0]       cand_reg, cand_next;
    logic [CNT_W-1:0] match_reg, match_next, match_inc;
    logic [CNT_W-1:0] rel_reg, rel_next, rel_inc;
    logic [3:0]       key_code_reg, key_code_next;
    logic             key_valid_reg, key_valid_next;
    logic             key_down_reg, key_down_next;
    logic             tick, advance, hit_one;
    logic [1:0]       hit_row;

    assign tick = (div_reg == DIV_LAST);
    assign div_next = tick ? '0 : div_reg + DIV_W'(1);

    // Ghosting (two or more rows low) is deliberately treated the same as no hit.
    always_comb begin
        hit_one = 1'b0;
        hit_row = 2'd0;
        case (row_sync_reg)
            4'b1110: begin hit_one = 1'b1; hit_row = 2'd0; end
            4'b1101: begin hit_one = 1'b1; hit_row = 2'd1; end
            4'b1011: begin hit_one = 1'b1; hit_row = 2'd2; end
            4'b0111: begin hit_one = 1'b1; hit_row = 2'd3; end
            default: begin hit_one = 1'b0; hit_row = 2'd0; end
        endcase
    end

    assign match_inc = (match_reg == CNT_DONE) ? match_reg : match_reg + CNT_W'(1);
    assign rel_inc   = (rel_reg == CNT_DONE) ? rel_reg : rel_reg + CNT_W'(1);

    always_comb begin
        state_next     = state_reg;
        col_idx_next   = col_idx_reg;
        col_out_next   = col_out_reg;
        cand_next      = cand_reg;
        match_next     = match_reg;
        rel_next       = rel_reg;
        key_code_next  = key_code_reg;
        key_valid_next = 1'b0;
        key_down_next  = key_down_reg;
        advance        = 1'b0;
        if (tick) begin
            case (state_reg)
                SCAN: begin
                    if (hit_one) begin
                        cand_next  = {hit_row, col_idx_reg};
                        match_next = CNT_W'(1);
                        state_next = DEBOUNCE;
                    end else begin
                        advance = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    // A row change on the completing tick aborts; nothing is accepted.
                    if (hit_one && hit_row == cand_reg[3:2]) begin
                        match_next = match_inc;
                        if (match_inc == CNT_DONE) begin
                            key_code_next  = cand_reg;
                            key_valid_next = 1'b1;
                            key_down_next  = 1'b1;
                            rel_next       = '0;
                            state_next     = HELD;
                        end
                    end else begin
                        state_next = SCAN;
                        advance    = 1'b1;
                    end
                end
                HELD: begin
                    if (row_sync_reg == 4'hF) begin
                        rel_next = rel_inc;
                        if (rel_inc == CNT_DONE) begin
                            state_next    = SCAN;
                            key_down_next = 1'b0;
                            advance       = 1'b1;
                        end
                    end else begin
                        rel_next = '0;
                    end
                end
                default: state_next = SCAN;
            endcase
        end
        if (advance) begin
            col_idx_next = col_idx_reg + 2'd1;
            col_out_next = ~(4'b0001 << col_idx_next);
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg     <= SCAN;
            row_meta_reg  <= 4'hF;
            row_sync_reg  <= 4'hF;
            div_reg       <= '0;
            col_idx_reg   <= 2'd0;
            col_out_reg   <= 4'b1110;
            cand_reg      <= 4'h0;
            match_reg     <= '0;
            rel_reg       <= '0;
            key_code_reg  <= 4'h0;
            key_valid_reg <= 1'b0;
            key_down_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            row_meta_reg  <= row_in;
            row_sync_reg  <= row_meta_reg;
            div_reg       <= div_next;
            col_idx_reg   <= col_idx_next;
            col_out_reg   <= col_out_next;
            cand_reg      <= cand_next;
            match_reg     <= match_next;
            rel_reg       <= rel_next;
            key_code_reg  <= key_code_next;
            key_valid_reg <= key_valid_next;
            key_down_reg  <= key_down_next;
        end
    end

    assign col_out   = col_out_reg;
    assign key_code  = key_code_reg;
    assign key_valid = key_valid_reg;
    assign key_down  = key_down_reg;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: key-matrix model drives rows from col_out; a per-dwell
// reference model predicts column, key_valid, key_down and key_code every cycle.
module tb_keypad_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DS       = 3;

    logic       clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out, key_code;
    logic       key_valid, key_down;
    logic [15:0] keys = 16'h0;   // bit r*4+c = key at row r, column c pressed

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DS)) dut (
        .clk(clk), .sys_rst_n(sys_rst_n), .row_in(row_in),
        .col_out(col_out), .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            row_in[r] = ~(|(keys[r*4 +: 4] & ~col_out));
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one step per column dwell, following the press/release rules.
    int         n_edges;
    int         m_mode;   // 0 scanning, 1 confirming a candidate, 2 key held
    int         m_col, m_cand_row, m_cand_col, m_cnt, m_rel;
    logic [3:0] m_code;
    logic       m_valid, m_down;
    int         pulses;
    logic [3:0] codes[$];

    function automatic logic [3:0] col_mask(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c);
    endfunction

    task automatic model_reset();
        n_edges = 0; m_mode = 0; m_col = 0; m_cnt = 0; m_rel = 0;
        m_cand_row = 0; m_cand_col = 0;
        m_code = 4'h0; m_valid = 1'b0; m_down = 1'b0;
    endtask

    task automatic model_tick();
        int nlow, row;
        nlow = 0; row = 0;
        for (int r = 0; r < 4; r++)
            if (keys[r*4 + m_col]) begin nlow++; row = r; end
        if (m_mode == 0) begin
            if (nlow == 1) begin
                m_cand_row = row; m_cand_col = m_col; m_cnt = 1; m_mode = 1;
            end else m_col = (m_col + 1) % 4;
        end else if (m_mode == 1) begin
            if (nlow == 1 && row == m_cand_row) begin
                m_cnt++;
                if (m_cnt == DS) begin
                    m_code = 4'(m_cand_row * 4 + m_cand_col);
                    m_valid = 1'b1; m_down = 1'b1; m_rel = 0; m_mode = 2;
                end
            end else begin
                m_mode = 0; m_col = (m_col + 1) % 4;
            end
        end else begin
            if (nlow == 0) begin
                m_rel++;
                if (m_rel == DS) begin
                    m_mode = 0; m_down = 1'b0; m_col = (m_col + 1) % 4;
                end
            end else m_rel = 0;
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        n_edges++;
        m_valid = 1'b0;
        if (n_edges % SCAN_DIV == 0) model_tick();
        @(negedge clk);
        check("col_out", col_out, col_mask(m_col));
        check("key_valid", key_valid, m_valid);
        check("key_down", key_down, m_down);
        check("key_code", key_code, m_code);
        if (key_valid) begin
            pulses++;
            codes.push_back(key_code);
            $display("key_valid pulse code=%0h at %0t", key_code, $time);
        end
    endtask

    // Keys change only right after a dwell boundary so the synchronizer settles.
    task automatic run_ticks(input logic [15:0] k, input int t);
        keys = k;
        for (int i = 0; i < t * SCAN_DIV; i++) step_cycle();
    endtask

    function automatic logic [15:0] key_bit(input int r, input int c);
        logic [15:0] one;
        one = 16'h1;
        return one << (r * 4 + c);
    endfunction

    task automatic apply_reset();
        sys_rst_n = 1'b0;
        #1;
        check("rst col_out", col_out, 4'b1110);
        check("rst key_down", key_down, 1'b0);
        check("rst key_code", key_code, 4'h0);
        check("rst key_valid", key_valid, 1'b0);
        @(negedge clk);
        @(negedge clk);
        sys_rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int p0, guard;
        model_reset();
        pulses = 0;
        @(negedge clk);
        apply_reset();

        // Idle scanning: column rotates each dwell, nothing reported.
        p0 = pulses;
        run_ticks(16'h0, 8);
        check("idle pulses", pulses - p0, 0);

        // Held key row 2 / column 1.
        p0 = pulses;
        run_ticks(key_bit(2, 1), 10);
        check("hold pulses", pulses - p0, 1);
        check("hold code", key_code, 4'b1001);
        check("hold down", key_down, 1'b1);
        check("hold col", col_out, 4'b1101);
        run_ticks(16'h0, 5);
        check("release down", key_down, 1'b0);

        // Bounce: present for only two dwells of column 1.
        guard = 0;
        while (m_col != 1 && guard < 8) begin run_ticks(16'h0, 1); guard++; end
        check("align col", m_col < 4 && guard < 8, 1);
        p0 = pulses;
        run_ticks(key_bit(2, 1), 2);
        run_ticks(16'h0, 1);
        check("bounce resume col", col_out, 4'b1011);
        run_ticks(16'h0, 4);
        check("bounce pulses", pulses - p0, 0);
        check("bounce code kept", key_code, 4'b1001);

        // Ghosting: rows 0 and 3 both low on column 2.
        p0 = pulses;
        run_ticks(key_bit(0, 2) | key_bit(3, 2), 25);
        check("ghost pulses", pulses - p0, 0);
        run_ticks(16'h0, 2);

        // Two presses in sequence.
        p0 = pulses;
        codes.delete();
        run_ticks(key_bit(3, 3), 10);
        run_ticks(16'h0, 5);
        check("between down", key_down, 1'b0);
        run_ticks(key_bit(0, 0), 10);
        run_ticks(16'h0, 5);
        check("seq pulses", pulses - p0, 2);
        check("seq code0", (codes.size() > 0) ? codes[0] : 4'h5, 4'hF);
        check("seq code1", (codes.size() > 1) ? codes[1] : 4'h5, 4'h0);

        // Reset while held on key 1/2, key kept pressed through and after reset.
        run_ticks(key_bit(1, 2), 10);
        check("pre-rst down", key_down, 1'b1);
        check("pre-rst code", key_code, 4'h6);
        apply_reset();
        p0 = pulses;
        run_ticks(key_bit(1, 2), 4);
        check("rst no early accept", pulses - p0, 0);
        run_ticks(key_bit(1, 2), 6);
        check("rst reaccept", pulses - p0, 1);
        check("rst reaccept code", key_code, 4'h6);
        run_ticks(16'h0, 5);

        // Randomized presses, releases and ghost patterns.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] k;
            int kind;
            kind = $urandom_range(0, 3);
            k = 16'h0;
            if (kind == 1 || kind == 3)
                k = key_bit($urandom_range(0, 3), $urandom_range(0, 3));
            else if (kind == 2)
                k = key_bit($urandom_range(0, 3), $urandom_range(0, 3)) |
                    key_bit($urandom_range(0, 3), $urandom_range(0, 3));
            run_ticks(k, $urandom_range(1, 8));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad and reports one debounced key code per press. It is the input-side counterpart of the multiplexed display path: the display selector drives digit-select lines and pushes data out, while this block drives column-select lines and reads row returns back in. It sits beside the `key_test` debouncers in the stopwatch top. Its `key_code`/`key_valid` output feeds preset loading and mode entry.

## Interface
Parameters:
- SCAN_DIV, 50000 — clk cycles per column dwell (1 ms at 50 MHz); legal range ≥ 4.
- DEBOUNCE_SCANS, 4 — consecutive matching samples required to accept a press or a release; legal range ≥ 2.

Ports:
- clk  input  1  system clock; the only clock.
- sys_rst_n  input  1  reset, asynchronous and active-low.
- row_in  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
- col_out  output  4  column drive, active-low, exactly one bit low at all times.
- key_code  output  4  last accepted key, {row[1:0], col[1:0]}.
- key_valid  output  1  one-cycle pulse when key_code is updated.
- key_down  output  1  high while the accepted key is held (state HELD).

## Operation
- row_in passes through a 2-flop synchronizer before any use.
- Divider counts 0..SCAN_DIV-1 and wraps. `tick` is asserted in the cycle where the count equals SCAN_DIV-1.
- Rows are sampled only on tick, at the end of a column dwell, so the synchronized rows have settled.
- A sample is a "single hit" when exactly one synchronized row bit is 0. Row index r is the position of that 0 bit.
- A sample with zero rows low, or with two or more rows low, is "no hit". Multi-key ghosting is ignored, never reported.
- FSM states and transitions:
  - SCAN: column index advances 0→1→2→3→0 on each tick.
    - On a tick with a single hit: latch cand={r,col}, set match_cnt=1, go to DEBOUNCE. The column stays frozen.
  - DEBOUNCE: column frozen. On each tick:
    - Single hit at the same row: match_cnt++. When match_cnt reaches DEBOUNCE_SCANS: key_code<=cand, pulse key_valid, go to HELD.
    - Otherwise (release, different row, or multi-row): go to SCAN and advance the column on that tick. No output change.
  - HELD: column frozen, key_down=1. On each tick:
    - All rows high: rel_cnt++.
    - Any row low: rel_cnt=0.
    - When rel_cnt reaches DEBOUNCE_SCANS: go to SCAN, key_down=0, advance the column.
- Only one key_valid per press, regardless of hold duration. No auto-repeat.
- key_code holds its value until the next accepted press. It is not cleared on release.
- Counters: the divider is ⌈log2(SCAN_DIV)⌉ bits; match_cnt and rel_cnt are ⌈log2(DEBOUNCE_SCANS+1)⌉ bits and saturate, never wrap.

## Timing
- Reset values (asynchronous):
  - state=SCAN, divider=0, column=0.
  - col_out=4'b1110, key_code=4'h0, key_valid=0, key_down=0.
  - Synchronizer flops reset to 1 (no press).
- col_out is registered and changes in the cycle after tick.
- key_valid is registered. It is high for exactly the one cycle after the tick that completes debounce, and key_down rises in that same cycle.
- Minimum press-to-key_valid: the press must be present in the synchronized rows across DEBOUNCE_SCANS consecutive ticks of its column.
- Worst-case press-to-key_valid: (4 + DEBOUNCE_SCANS) × SCAN_DIV + 2 cycles.
- key_down falls in the cycle after the DEBOUNCE_SCANS-th consecutive all-high tick.
- A repress of the same key is accepted only after HELD has exited, then through a full DEBOUNCE pass.
- Reset asserted mid-DEBOUNCE or mid-HELD: immediate return to reset values, no key_valid emitted. Scanning restarts at column 0 after release of reset.
- Simultaneous events on a tick in DEBOUNCE where the row changes: the abort takes priority and nothing is accepted.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_SCANS=3; a key model pulls row r low while col_out[c]==0.
- Idle after reset, no keys -> col_out cycles 1110→1101→1011→0111→1110 every 4 clk; key_valid never asserts; key_code=0.
- Hold row 2/col 1 for 40 cycles -> exactly one key_valid pulse with key_code=4'b1001; key_down=1 from that cycle; col_out frozen at 1101 while held.
- Row 2/col 1 pressed for 2 ticks then released (bounce) -> no key_valid; key_code unchanged; scanning resumes at column 2.
- Rows 0 and 3 both low on column 2 -> no key_valid for 100 cycles; column never freezes.
- Press 3/3, release for ≥3 ticks, press 0/0 -> two pulses with codes 4'hF then 4'h0; key_down drops between them.
- sys_rst_n pulsed low while in HELD on key 1/2 -> col_out=1110, key_down=0, key_code=0 during reset, with no key_valid. Re-accept after release of reset requires a full debounce (3 matching ticks).
